// File: rtl/conv_scan_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// conv_scan_ctrl_pkg: shared conv-layer encodings, geometry and helpers
// Revision: 1.0
// ----------------------------------------------------------------------
package conv_scan_ctrl_pkg;

  localparam int C_IMG_W     = 28;
  localparam int C_I_MIN_DEF = 1;
  localparam int C_I_MAX_DEF = C_IMG_W - 2;
  localparam int C_J_MIN_DEF = 1;
  localparam int C_J_MAX_DEF = C_IMG_W - 2;
  localparam int C_ADDR_W    = 10;

  localparam logic [2:0] C_ST_IDLE    = 3'd0;
  localparam logic [2:0] C_ST_ISSUE   = 3'd1;
  localparam logic [2:0] C_ST_WAIT    = 3'd2;
  localparam logic [2:0] C_ST_PRESENT = 3'd3;
  localparam logic [2:0] C_ST_DONE    = 3'd4;

  // Output-map address with wide intermediates, truncated to C_ADDR_W bits.
  function automatic logic [C_ADDR_W-1:0] f_out_addr(
    input logic [4:0]          i,
    input logic [4:0]          j,
    input logic [4:0]          i_min,
    input logic [4:0]          j_min,
    input logic [C_ADDR_W-1:0] row_w
  );
    logic [C_ADDR_W-1:0]   di;
    logic [C_ADDR_W-1:0]   dj;
    logic [2*C_ADDR_W-1:0] prod;
    di   = {{(C_ADDR_W-5){1'b0}}, i} - {{(C_ADDR_W-5){1'b0}}, i_min};
    dj   = {{(C_ADDR_W-5){1'b0}}, j} - {{(C_ADDR_W-5){1'b0}}, j_min};
    prod = {{C_ADDR_W{1'b0}}, di} * {{C_ADDR_W{1'b0}}, row_w};
    return prod[C_ADDR_W-1:0] + dj;
  endfunction

endpackage

`default_nettype wire

// File: rtl/conv_scan_ctrl_counter.sv
`default_nettype none
// ----------------------------------------------------------------------
// scan_index_counter: bounded nested i/j counter with clear and last flag
// Revision: 1.0
// ----------------------------------------------------------------------
module scan_index_counter
  import conv_scan_ctrl_pkg::*;
#(
  parameter int I_MIN = C_I_MIN_DEF,
  parameter int I_MAX = C_I_MAX_DEF,
  parameter int J_MIN = C_J_MIN_DEF,
  parameter int J_MAX = C_J_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clear,
  input  logic       i_advance,
  output logic [4:0] o_i,
  output logic [4:0] o_j,
  output logic [4:0] o_nxt_i,
  output logic [4:0] o_nxt_j,
  output logic       o_last
);

  localparam logic [4:0] C_I_MIN = 5'(I_MIN);
  localparam logic [4:0] C_I_MAX = 5'(I_MAX);
  localparam logic [4:0] C_J_MIN = 5'(J_MIN);
  localparam logic [4:0] C_J_MAX = 5'(J_MAX);

  logic [4:0] r_i;
  logic [4:0] r_j;
  logic [4:0] w_nxt_i;
  logic [4:0] w_nxt_j;

  // At the final position an advance holds; the owner decides what happens next.
  always_comb begin
    w_nxt_i = r_i;
    w_nxt_j = r_j;
    if (i_clear) begin
      w_nxt_i = C_I_MIN;
      w_nxt_j = C_J_MIN;
    end else if (i_advance) begin
      if (r_j < C_J_MAX) begin
        w_nxt_j = r_j + 5'd1;
      end else if (r_i < C_I_MAX) begin
        w_nxt_j = C_J_MIN;
        w_nxt_i = r_i + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_i <= C_I_MIN;
      r_j <= C_J_MIN;
    end else begin
      r_i <= w_nxt_i;
      r_j <= w_nxt_j;
    end
  end

  assign o_i     = r_i;
  assign o_j     = r_j;
  assign o_nxt_i = w_nxt_i;
  assign o_nxt_j = w_nxt_j;
  assign o_last  = (r_i == C_I_MAX) && (r_j == C_J_MAX);

endmodule

`default_nettype wire

// File: rtl/conv_scan_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------
// conv_scan_ctrl: sequences one 3x3 conv pass with BRAM-latency wait
// Revision: 1.0
// ----------------------------------------------------------------------
module conv_scan_ctrl
  import conv_scan_ctrl_pkg::*;
#(
  parameter int I_MIN   = C_I_MIN_DEF,
  parameter int I_MAX   = C_I_MAX_DEF,
  parameter int J_MIN   = C_J_MIN_DEF,
  parameter int J_MAX   = C_J_MAX_DEF,
  parameter int MEM_LAT = 1,
  parameter int OUT_W   = C_IMG_W - 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic                i_patch_ready,
  output logic [4:0]          o_i,
  output logic [4:0]          o_j,
  output logic                o_addr_gen,
  output logic                o_row_start,
  output logic                o_patch_valid,
  output logic [C_ADDR_W-1:0] o_out_addr,
  output logic                o_busy,
  output logic                o_done
);

  localparam logic [4:0]          C_I_MIN   = 5'(I_MIN);
  localparam logic [4:0]          C_J_MIN   = 5'(J_MIN);
  localparam logic [2:0]          C_MEM_LAT = 3'(MEM_LAT);
  localparam logic [C_ADDR_W-1:0] C_OUT_W   = C_ADDR_W'(OUT_W);

  logic [2:0]          r_state;
  logic [2:0]          r_cnt;
  logic                r_addr_gen;
  logic                r_row_start;
  logic                r_patch_valid;
  logic [C_ADDR_W-1:0] r_out_addr;
  logic                r_busy;
  logic                r_done;

  logic                w_clear;
  logic                w_xfer;
  logic                w_last;
  logic                w_advance;
  logic [4:0]          w_nxt_i;
  logic [4:0]          w_nxt_j;
  logic [C_ADDR_W-1:0] w_nxt_addr;

  assign w_clear    = (r_state == C_ST_IDLE) && i_start;
  assign w_xfer     = (r_state == C_ST_PRESENT) && i_patch_ready;
  assign w_advance  = w_xfer && !w_last;
  assign w_nxt_addr = f_out_addr(w_nxt_i, w_nxt_j, C_I_MIN, C_J_MIN, C_OUT_W);

  scan_index_counter #(
    .I_MIN (I_MIN),
    .I_MAX (I_MAX),
    .J_MIN (J_MIN),
    .J_MAX (J_MAX)
  ) u_idx (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_clear),
    .i_advance (w_advance),
    .o_i       (o_i),
    .o_j       (o_j),
    .o_nxt_i   (w_nxt_i),
    .o_nxt_j   (w_nxt_j),
    .o_last    (w_last)
  );

  // Issue-cycle outputs are loaded on the edge entering ISSUE from the
  // counter's next position, so they line up with the updated i/j.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= C_ST_IDLE;
      r_cnt         <= 3'd0;
      r_addr_gen    <= 1'b0;
      r_row_start   <= 1'b0;
      r_patch_valid <= 1'b0;
      r_out_addr    <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_addr_gen  <= 1'b0;
      r_row_start <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        C_ST_IDLE: begin
          if (i_start) begin
            r_state     <= C_ST_ISSUE;
            r_cnt       <= C_MEM_LAT;
            r_busy      <= 1'b1;
            r_addr_gen  <= 1'b1;
            r_row_start <= (w_nxt_j == C_J_MIN);
            r_out_addr  <= w_nxt_addr;
          end
        end
        C_ST_ISSUE: begin
          r_cnt   <= C_MEM_LAT;
          r_state <= C_ST_WAIT;
        end
        C_ST_WAIT: begin
          r_cnt <= r_cnt - 3'd1;
          if (r_cnt <= 3'd1) begin
            r_state       <= C_ST_PRESENT;
            r_patch_valid <= 1'b1;
          end
        end
        C_ST_PRESENT: begin
          if (i_patch_ready) begin
            r_patch_valid <= 1'b0;
            if (w_last) begin
              r_state <= C_ST_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state     <= C_ST_ISSUE;
              r_addr_gen  <= 1'b1;
              r_row_start <= (w_nxt_j == C_J_MIN);
              r_out_addr  <= w_nxt_addr;
            end
          end
        end
        C_ST_DONE: begin
          r_state <= C_ST_IDLE;
        end
        default: begin
          r_state <= C_ST_IDLE;
        end
      endcase
    end
  end

  assign o_addr_gen    = r_addr_gen;
  assign o_row_start   = r_row_start;
  assign o_patch_valid = r_patch_valid;
  assign o_out_addr    = r_out_addr;
  assign o_busy        = r_busy;
  assign o_done        = r_done;

endmodule

`default_nettype wire

// File: doc/conv_scan_ctrl.md
Name: conv_scan_ctrl

Overview:
- Sequences one 3x3 convolution pass over a feature map by driving the patch address generator's (i, j, addr_gen) inputs.
- Waits for the pixel BRAM read latency, then presents a patch-valid strobe to the MAC array with a valid/ready handshake.
- Produces the matching output-map write address for each result.
- Sits between the layer-level sequencer (start/done) and the patch address generator / MAC datapath of one conv layer.

Parameters:
- I_MIN, 1, first row index issued.
- I_MAX, 26, last row index issued (inclusive).
- J_MIN, 1, first column index issued.
- J_MAX, 26, last column index issued (inclusive).
- MEM_LAT, 1, pixel BRAM read latency in cycles, counted after the address generator's registered output. Legal range 1..7.
- OUT_W, 26, output-map row width used for out_addr.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse that begins a pass; ignored unless in IDLE
- patch_ready  in  1  MAC accepts the presented patch
- i  out  5  row index to the address generator
- j  out  5  column index to the address generator
- addr_gen  out  1  one-cycle enable to the address generator
- row_start  out  1  high with addr_gen when j == J_MIN (first patch of a row)
- patch_valid  out  1  patch data at the BRAM outputs is stable
- out_addr  out  10  output-map address of the presented patch
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the last patch handshake

Behaviour:
- Reset values: state IDLE; i=I_MIN, j=J_MIN; addr_gen, row_start, patch_valid, busy, done all 0; out_addr=0; wait counter 0.
- All outputs are registered.
- IDLE:
  - start=1 loads i=I_MIN, j=J_MIN and the wait counter, then goes to ISSUE.
  - busy rises in the same edge.
- ISSUE (one cycle):
  - addr_gen=1; row_start=(j==J_MIN).
  - out_addr=(i-I_MIN)*OUT_W+(j-J_MIN), truncated to 10 bits.
  - Wait counter loaded with MEM_LAT. Goes to WAIT.
- WAIT:
  - addr_gen=0; counter decrements each cycle.
  - On counter==1 -> PRESENT, so patch_valid first rises exactly 1+MEM_LAT cycles after the addr_gen cycle.
- PRESENT:
  - patch_valid=1 and out_addr held stable until patch_ready=1 is sampled.
  - Transfer occurs in the cycle where patch_valid & patch_ready; patch_valid drops the next cycle.
  - patch_ready while not in PRESENT is ignored.
- Advance on transfer:
  - If j<J_MAX: j<=j+1 -> ISSUE.
  - Else if i<I_MAX: j<=J_MIN, i<=i+1 -> ISSUE.
  - Else: DONE.
- DONE (one cycle): done=1, busy=0, return to IDLE. i and j hold their last values.
- i and j change only on the transfer edge and never while addr_gen=1, so the address generator's row-change detection stays valid.
- start during a pass (busy=1) or in DONE is ignored; no queuing.
- Total patches per pass: (I_MAX-I_MIN+1)*(J_MAX-J_MIN+1). With the defaults this is 676, and out_addr runs 0..675.
- Minimum cycles per patch: 1 (ISSUE) + MEM_LAT (WAIT) + 1 (PRESENT, ready already high).
- Asynchronous reset mid-pass: immediately returns to reset values; no done pulse. A following start begins a fresh pass from (I_MIN, J_MIN).
- Degenerate map (I_MIN==I_MAX, J_MIN==J_MAX): exactly one patch, then done.
- Widths: i and j are 5-bit unsigned. out_addr arithmetic uses at least 10-bit intermediates. Parameters must satisfy I_MIN<=I_MAX<=31 and J_MIN<=J_MAX<=31.

Decomposition:
- Shared conv package/include holds:
  - state encodings (IDLE, ISSUE, WAIT, PRESENT, DONE);
  - image geometry constants (28-pixel input width, default index bounds);
  - the 10-bit address width.
- One natural sub-module: scan_index_counter. It is a nested i/j counter with bounds, advance, clear and last-position flag. It is reused by the pooling controller. The FSM and latency counter stay in conv_scan_ctrl.

Test Plan:
- Reset then start with defaults, patch_ready tied 1:
  - addr_gen pulses 676 times, each 3 cycles apart.
  - First issue is (i=1, j=1, row_start=1, out_addr=0); last is (26, 26, out_addr=675).
  - done pulses once; busy is low afterwards.
- Row wrap: after the transfer at (1, 26) the next issue is (2, 1) with row_start=1 and out_addr=26.
- Backpressure at (1, 3): hold patch_ready=0 for 5 cycles.
  - patch_valid stays 1 and out_addr stays 2 throughout.
  - No new addr_gen; j advances to 4 only after ready rises.
- MEM_LAT=3: patch_valid rises exactly 4 cycles after each addr_gen.
- start pulsed again at patch 100: ignored; pass completes with exactly 676 transfers and one done.
- rst asserted mid-pass at (5, 7):
  - All outputs return to reset values immediately; no done pulse.
  - A new start re-issues (1, 1) with out_addr=0.
